// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states and RV32I lane access
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH];
    logic [31:0]         word_rd;
    logic [31:0]         shifted;
    logic [31:0]         load_data;
    logic [31:0]         merged;
    logic                mem_we;
    logic                misaligned;

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Alignment check on the incoming request; size 3 is never legal
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Load lane extract with sign/zero extension, and store lane merge, from the addressed word
    always_comb begin
        word_rd   = mem_q[addr_q[ADDR_W-1:2]];
        shifted   = word_rd >> {addr_q[1:0], 3'b000};
        load_data = shifted;
        merged    = word_rd;
        case (size_q)
            2'd0: begin
                load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'd1: begin
                load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_data = shifted;
                merged    = wdata_q;
            end
        endcase
    end

    // Write strobe: only a store that reaches its ACCESS edge outside reset touches RAM
    assign mem_we = rst_n && (state_q == S_ACCESS) && wr_q;

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (misaligned) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                rdata_d = wr_q ? 32'h0 : load_data;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q[ADDR_W-1:2]] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        sel;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata);
        req_wr       = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
    endtask

    task automatic do_req(input vec_t v);
        exp_t e;
        int   n;
        int   lat;
        int   exp_lat;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        exp_lat = v.exp_err ? 1 : (sel ? 2 : 4);
        rsp_ready = 1'b0;
        drive(v.wr, v.size, v.uns, v.addr, v.wdata);
        n = 0;
        while (!o_req_ready && n < 20) begin
            tick();
            n++;
        end
        check({v.name, "_req_ready"}, 32'(o_req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({v.name, "_latency"}, 32'(lat), 32'(exp_lat));
        e = sb.pop_front();
        check({v.name, "_rdata"}, o_rsp_rdata, e.rdata);
        check({v.name, "_err"}, 32'(o_rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({v.name, "_rsp_done"}, 32'(o_rsp_valid), 32'd0);
    endtask

    vec_t vecs_a[16];
    vec_t vecs_b[4];

    initial begin
        int n;
        vecs_a[0]  = '{"sw10",   1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs_a[1]  = '{"lw10a",  1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs_a[2]  = '{"sb11",   1'b1, 2'd0, 1'b0, 8'h11, 32'h000000AA, 32'h0,        1'b0};
        vecs_a[3]  = '{"lw10b",  1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'hDEADAAEF, 1'b0};
        vecs_a[4]  = '{"lb11",   1'b0, 2'd0, 1'b0, 8'h11, 32'h0,        32'hFFFFFFAA, 1'b0};
        vecs_a[5]  = '{"lbu11",  1'b0, 2'd0, 1'b1, 8'h11, 32'h0,        32'h000000AA, 1'b0};
        vecs_a[6]  = '{"sh12",   1'b1, 2'd1, 1'b0, 8'h12, 32'hFFFF1234, 32'h0,        1'b0};
        vecs_a[7]  = '{"lw10c",  1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'h1234AAEF, 1'b0};
        vecs_a[8]  = '{"lh12",   1'b0, 2'd1, 1'b0, 8'h12, 32'h0,        32'h00001234, 1'b0};
        vecs_a[9]  = '{"lh10",   1'b0, 2'd1, 1'b0, 8'h10, 32'h0,        32'hFFFFAAEF, 1'b0};
        vecs_a[10] = '{"lw13",   1'b0, 2'd2, 1'b0, 8'h13, 32'h0,        32'h0,        1'b1};
        vecs_a[11] = '{"sw12",   1'b1, 2'd2, 1'b0, 8'h12, 32'h0,        32'h0,        1'b1};
        vecs_a[12] = '{"lw10d",  1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'h1234AAEF, 1'b0};
        vecs_a[13] = '{"sz3",    1'b0, 2'd3, 1'b0, 8'h10, 32'h0,        32'h0,        1'b1};
        vecs_a[14] = '{"lb13",   1'b0, 2'd0, 1'b0, 8'h13, 32'h0,        32'h00000012, 1'b0};
        vecs_a[15] = '{"lhu10",  1'b0, 2'd1, 1'b1, 8'h10, 32'h0,        32'h0000AAEF, 1'b0};

        vecs_b[0]  = '{"b_sw40", 1'b1, 2'd2, 1'b0, 8'h40, 32'h0BADF00D, 32'h0,        1'b0};
        vecs_b[1]  = '{"b_lh42", 1'b0, 2'd1, 1'b0, 8'h42, 32'h0,        32'h00000BAD, 1'b0};
        vecs_b[2]  = '{"b_lh41", 1'b0, 2'd1, 1'b0, 8'h41, 32'h0,        32'h0,        1'b1};
        vecs_b[3]  = '{"b_lb40", 1'b0, 2'd0, 1'b0, 8'h40, 32'h0,        32'h0000000D, 1'b0};

        sel = 1'b0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 8'h0, 32'h0);
        req_valid = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(o_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", 32'(o_req_ready), 32'd1);

        for (int i = 0; i < 16; i++) do_req(vecs_a[i]);

        // response held off for 5 cycles while another request is offered
        drive(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        tick();
        n = 1;
        while (!o_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("hold_latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(o_rsp_valid), 32'd1);
            check("hold_rdata", o_rsp_rdata, 32'h1234AAEF);
            check("hold_req_ready", 32'(o_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("hold_done_valid", 32'(o_rsp_valid), 32'd0);
        check("hold_done_req_ready", 32'(o_req_ready), 32'd1);

        // rsp_ready already high when the response appears
        rsp_ready = 1'b1;
        drive(1'b0, 2'd0, 1'b1, 8'h12, 32'h0);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!o_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("early_ready_latency", 32'(n), 32'd4);
        check("early_ready_rdata", o_rsp_rdata, 32'h00000034);
        tick();
        check("early_ready_done", 32'(o_rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // address space wraps at the top word
        do_req('{"sw_fc", 1'b1, 2'd2, 1'b0, 8'hFC, 32'hCAFEF00D, 32'h0, 1'b0});
        do_req('{"lh_fe", 1'b0, 2'd1, 1'b0, 8'hFE, 32'h0, 32'hFFFFCAFE, 1'b0});

        // reset during WAIT of a store leaves RAM untouched
        do_req('{"sw20_pre", 1'b1, 2'd2, 1'b0, 8'h20, 32'h11111111, 32'h0, 1'b0});
        drive(1'b1, 2'd2, 1'b0, 8'h20, 32'h00000055);
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_wait_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_wait_req_ready", 32'(o_req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_wait_req_ready_after", 32'(o_req_ready), 32'd1);
        check("rst_wait_rsp_after", 32'(o_rsp_valid), 32'd0);
        do_req('{"lw20", 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 32'h11111111, 1'b0});

        // reset during RESP drops the response
        drive(1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!o_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("rst_resp_seen", 32'(o_rsp_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_resp_dropped", 32'(o_rsp_valid), 32'd0);
        check("rst_resp_rdata", o_rsp_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // zero-wait-state responder
        sel = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) do_req(vecs_b[i]);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
